key_debounce: RTL

Debounces one raw mechanical key or switch input and delivers a clean, synchronous, active-high level. The output feeds the team's positive-edge detector, which turns each debounced press into a single-cycle tick. Internally the block combines a two-flop synchroniser, a stability counter and a four-state FSM. There is one debounced output per instance; multi-key panels instantiate it per key.

---
 rtl/key_debounce_pkg.sv | 33 +++
 rtl/key_debounce_sync_2ff.sv | 36 +++
 rtl/key_debounce.sv | 124 ++++++++++++
 3 files changed

// File: rtl/key_debounce_pkg.sv
// -----------------------------------------------------------------------------
// key_debounce_pkg
// Shared definitions for the key debouncer:
//   - state_e : 2-bit FSM state encoding. Gray-ordered around the cycle
//               IDLE -> PRESS_WAIT -> PRESSED -> RELEASE_WAIT -> IDLE, so
//               every transition flips exactly one bit. As a result,
//               bit[1] is the debounced level and bit[1]^bit[0] is "busy".
//   - clog2   : ceiling log2, used to size the stability counter.
// No ports (package).
// -----------------------------------------------------------------------------
package key_debounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'b00,
        ST_PRESS_WAIT   = 2'b01,
        ST_PRESSED      = 2'b11,
        ST_RELEASE_WAIT = 2'b10
    } state_e;

    // Number of bits needed to hold the values 0 .. value-1.
    function automatic int clog2(input int unsigned value);
        int          result;
        int unsigned v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/key_debounce_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous input bit.
// While reset is asserted, both flops hold RESET_VAL so that the
// downstream logic sees a known, idle level the moment reset is released.
// Ports:
//   clk    : destination clock
//   rst_n  : asynchronous active-low reset
//   d_i    : asynchronous input
//   q_o    : synchronised output (second flop)
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= RESET_VAL;
            s2_q <= RESET_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Debounces one raw mechanical key/switch and delivers a clean, synchronous,
// active-high level. A raw change must be seen on DEBOUNCE_CYCLES consecutive
// synchronised samples before key_level follows it. Any single disagreeing
// sample restarts qualification from zero.
// Parameters:
//   DEBOUNCE_CYCLES : consecutive stable samples required (>= 2)
//   ACTIVE_LOW      : 1 = key reads 0 when pressed (pull-up wiring)
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   key_in    : raw key pin, asynchronous, may bounce
//   key_level : debounced level, 1 = pressed (registered)
//   busy      : 1 while a candidate transition is being qualified (registered)
// -----------------------------------------------------------------------------
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_level,
    output logic busy
);

    localparam int               CNT_W    = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             key_raw_s;
    logic             key_s;
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [1:0]       state_bits;

    // Reset value is the released raw level, so a key held through reset
    // is seen as a fresh press afterwards and re-qualified in full.
    sync_2ff #(
        .RESET_VAL (1'(ACTIVE_LOW))
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (key_in),
        .q_o   (key_raw_s)
    );

    assign key_s = ACTIVE_LOW ? ~key_raw_s : key_raw_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt counts consecutive samples agreeing with the candidate level.
    // Entering a WAIT state already counts the first sample (cnt=1), so the
    // transition fires on the DEBOUNCE_CYCLES-th sample while cnt holds
    // DEBOUNCE_CYCLES-1; the counter therefore never exceeds its range.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (key_s) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!key_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!key_s) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (key_s) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode straight from the state register (Gray encoding):
    // bit[1] = level, the WAIT states are the ones whose bits differ.
    assign state_bits = state_q;
    assign key_level  = state_bits[1];
    assign busy       = state_bits[1] ^ state_bits[0];

endmodule
